mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock, `clock`; `reset` SHALL be asynchronous and active-high.
REQ-002 Parameter `ADDR_W`, default 32: width of all address ports.
REQ-003 Parameter `DATA_W`, default 32: width of all data ports.
REQ-004 Parameter `MEM_LAT`, default 1, legal range 1..15: cycles from the `m_en` cycle to the cycle in which `m_rdata` is valid.
REQ-005 Clock and reset ports:
- `clock` in 1: system clock.
- `reset` in 1: async active-high reset.
REQ-006 Fetch-requester ports:
- `i_req` in 1: fetch request.
- `i_addr` in ADDR_W: fetch address.
- `i_ready` out 1: fetch request accepted this cycle.
- `i_valid` out 1: fetch response valid.
- `i_rdata` out DATA_W: fetched instruction.
REQ-007 Data-requester ports:
- `d_req` in 1: load/store request.
- `d_we` in 1: store when 1.
- `d_size` in 2: access size, same encoding as data_memory `size_in`.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_ready` out 1: data request accepted.
- `d_valid` out 1: load data valid or store complete.
- `d_rdata` out DATA_W: load data.
REQ-008 Memory-side ports:
- `m_en` out 1: memory access strobe.
- `m_we` out 1: write enable.
- `m_size` out 2: access size.
- `m_addr` out ADDR_W: address.
- `m_wdata` out DATA_W: write data.
- `m_rdata` in DATA_W: memory read data.
- `busy` out 1: high whenever the state is not IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with at most one outstanding transaction.
REQ-010 In IDLE with any `req` high, the block SHALL assert exactly one of `i_ready`/`d_ready` (combinational), latch the winner's owner, address, size, write enable and write data, and go to ISSUE.
REQ-011 `i_ready` and `d_ready` SHALL be 0 in every state other than IDLE, and also in IDLE when the corresponding `req` is 0.
REQ-012 ISSUE (1 cycle): `m_en`=1 and `m_*` SHALL be driven from the latched registers; fetch SHALL use `m_we`=0 and `m_size`=SIZE_WORD. The FSM SHALL load the latency counter with MEM_LAT and go to WAIT.
REQ-013 WAIT SHALL last exactly MEM_LAT cycles; in its last cycle the block SHALL register `m_rdata` when the owner's access is a read; the FSM SHALL then go to RESP.
REQ-014 RESP (1 cycle): the owner's `valid`=1 with the registered data, then the FSM SHALL go to IDLE. Timing: accept at T gives valid at T+2+MEM_LAT, and the next accept is possible at T+3+MEM_LAT.
REQ-015 Outside ISSUE, `m_en`=0, `m_we`=0, and `m_addr`/`m_wdata`/`m_size` SHALL hold their last values.
REQ-016 `i_rdata`/`d_rdata` SHALL update only on reads and SHALL otherwise hold; on a store, `d_valid` SHALL pulse in RESP and `d_rdata` SHALL be unchanged.
REQ-017 Simultaneous `i_req` and `d_req` in IDLE SHALL be resolved per REQ-022/REQ-023; a lone request SHALL always win.
REQ-018 Deasserting or changing `req`/`addr` after acceptance SHALL NOT affect the in-flight transaction; a `req` dropped before acceptance SHALL have no effect.
REQ-019 Addresses SHALL pass through unchecked; alignment is the requester's responsibility.

Reset
REQ-020 While `reset` is high, the FSM SHALL be IDLE and all outputs SHALL be 0: ready, valid, rdata, `m_*` and `busy`. The counter and latched registers SHALL clear.
REQ-021 Reset mid-transaction SHALL abort the transaction with no `valid` pulse, and SHALL clear the round-robin pointer to OWN_D.

Configuration
REQ-022 With `ARB_RR_EN` defined: a `last_owner` register SHALL be updated on each accept, and a tie SHALL grant the port not granted last; after reset the first tie SHALL go to fetch.
REQ-023 Without `ARB_RR_EN`: fixed priority, and the data port SHALL win every tie (fetch starvation is permitted); no `last_owner` flop SHALL exist.

Structure
REQ-024 Package `mem_arb_pkg` SHALL hold:
- the state enum (IDLE/ISSUE/WAIT/RESP),
- the owner enum (OWN_I/OWN_D),
- SIZE_WORD (2'b11),
- the default MEM_LAT.
REQ-025 The counter width SHALL be $clog2(MEM_LAT+1).
REQ-026 One combinational sub-module, `arb_pick`, SHALL compute the grant from `i_req`, `d_req` and `last_owner`; the rest of the logic is flat.

Verification
REQ-027 Lone fetch: MEM_LAT=1, `i_req`=1 with `i_addr`=0x00400000 at T, `m_rdata`=0x20080005 at T+2 -> `i_ready`@T, `m_en`@T+1 with addr 0x00400000 and `m_we`=0, `i_valid`@T+3 with `i_rdata`=0x20080005.
REQ-028 Store: `d_req`, `d_we`=1, `d_size`=2'b00, `d_addr`=0x10010003, `d_wdata`=0x41 -> `m_en`/`m_we`=1 one cycle with those values; `d_valid`@T+3; `d_rdata` unchanged.
REQ-029 Tie, fixed priority: `i_req`=`d_req`=1 for 3 back-to-back transactions -> three data grants, zero fetch grants; after `d_req` drops, fetch is granted in the next IDLE.
REQ-030 Tie with `ARB_RR_EN`: four transactions with both requests held -> grant order I, D, I, D.
REQ-031 MEM_LAT=4 and reset: load accepted at T -> `d_valid`@T+6; a second run with reset asserted at T+3 -> no `d_valid`, all outputs 0, `busy`=0, and a fresh `i_req` is accepted in the first cycle after reset deasserts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_WORD   = 2'b11;
  localparam int         MEM_LAT_DEF = 1;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - grant selection between fetch and data requesters
// On a tie the port not granted last wins; fixed-priority builds feed last_owner as OWN_I.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   grant_i,
  output logic   grant_d,
  output owner_t winner
);

  always_comb begin
    winner  = OWN_I;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req && (!i_req || last_owner == OWN_I)) begin
      winner = OWN_D;
    end
    if (i_req || d_req) begin
      grant_i = (winner == OWN_I);
      grant_d = (winner == OWN_D);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter of fetch and data ports onto one memory
// Define ARB_RR_EN for round-robin tie breaking; default build gives the data port fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  owner_t            lat_owner;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              grant_i, grant_d, ready_i, ready_d;
  owner_t            winner, last_owner;
  logic              accept, wait_last;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .winner     (winner)
  );

  always_comb begin
    next_state = state;
    ready_i    = 1'b0;
    ready_d    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i || grant_d) begin
          ready_i    = grant_i;
          ready_d    = grant_d;
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (wait_last) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign accept    = (state == IDLE) && (grant_i || grant_d);
  assign wait_last = (cnt == CNT_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_owner <= OWN_I;
      lat_we    <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_owner <= winner;
        if (winner == OWN_D) begin
          lat_we    <= d_we;
          lat_size  <= d_size;
          lat_addr  <= d_addr;
          lat_wdata <= d_wdata;
        end else begin
          // Fetch keeps the previous write data so m_wdata only moves on data accesses.
          lat_we   <= 1'b0;
          lat_size <= SIZE_WORD;
          lat_addr <= i_addr;
        end
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(MEM_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (wait_last && !lat_we) begin
          if (lat_owner == OWN_I) i_rdata_q <= m_rdata;
          else                    d_rdata_q <= m_rdata;
        end
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_owner <= OWN_D;
    end else if (accept) begin
      last_owner <= winner;
    end
  end
`else
  assign last_owner = OWN_I;
`endif

  // Ready is combinational from the requests, so it is masked while reset is held.
  assign i_ready = ready_i && !reset;
  assign d_ready = ready_d && !reset;
  assign i_valid = (state == RESP) && (lat_owner == OWN_I);
  assign d_valid = (state == RESP) && (lat_owner == OWN_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = (state == ISSUE);
  assign m_we    = (state == ISSUE) && lat_we;
  assign m_size  = lat_size;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [1:0]  d_size = '0;
  logic        i_ready, i_valid, d_ready, d_valid, m_en, m_we, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic we; logic [1:0] size; logic [31:0] wdata; } issue_t;
  typedef struct { bit own_d; logic [31:0] ird; logic [31:0] drd; int at; } resp_t;

  issue_t      exp_iss[$];
  resp_t       exp_rsp[$];
  int          n_vec = 0, n_fail = 0;
  int          free_at = 0, last_acc = -100;
  bit          m_last_d = 1'b1;
  logic [31:0] m_ird = '0, m_drd = '0, m_wd = '0;
  int          rd_cyc = -1;
  logic [31:0] rd_val = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    free_at  = cyc;
    last_acc = -100;
    m_last_d = 1'b1;
    m_ird    = '0;
    m_drd    = '0;
    m_wd     = '0;
    exp_iss.delete();
    exp_rsp.delete();
  endtask

  // Called at posedge+1: drives one cycle of requests and predicts the handshake.
  task automatic apply(input logic ir, input logic dr, input logic [31:0] ia, input logic [31:0] da,
                       input logic dwe, input logic [1:0] ds, input logic [31:0] dwd);
    logic [1:0] exp_rdy;
    bit tie_d, win_d;
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_we = dwe; d_size = ds; d_wdata = dwd;
    exp_rdy = 2'b00;
    if (cyc >= free_at && (ir || dr)) begin
`ifdef ARB_RR_EN
      tie_d = !m_last_d;
`else
      tie_d = 1'b1;
`endif
      win_d = dr && (!ir || tie_d);
      if (win_d) begin
        exp_rdy = 2'b01;
        exp_iss.push_back('{da, dwe, ds, dwd});
        m_wd = dwd;
        if (!dwe) m_drd = mem_val(da);
      end else begin
        exp_rdy = 2'b10;
        exp_iss.push_back('{ia, 1'b0, 2'b11, m_wd});
        m_ird = mem_val(ia);
      end
      exp_rsp.push_back('{win_d, m_ird, m_drd, cyc + 2 + LAT});
      m_last_d = win_d;
      last_acc = cyc;
      free_at  = cyc + 3 + LAT;
    end
    #1;
    chk("ready", {i_ready, d_ready}, exp_rdy);
  endtask

  task automatic idle_until_free();
    for (int k = 0; k < 40 && cyc < free_at; k++) begin
      @(posedge clock); #1;
      apply(1'b0, 1'b0, '0, '0, 1'b0, 2'b00, '0);
    end
    chk("idle_reached", cyc >= free_at, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hs"}, {i_ready, d_ready, i_valid, d_valid, m_en, m_we, busy}, 0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    chk({tag, "_maddr"}, {m_addr, m_size}, 0);
    chk({tag, "_mwdata"}, m_wdata, 0);
  endtask

  // Memory: correct data only in the cycle MEM_LAT after the strobe, noise otherwise.
  initial begin
    forever begin
      @(posedge clock); #1;
      m_rdata = (cyc == rd_cyc) ? rd_val : $urandom();
    end
  end

  issue_t mi;
  resp_t  mr;
  always @(negedge clock) begin
    if (!reset) begin
      chk("busy", busy, (cyc > last_acc) && (cyc < free_at));
      if (m_en) begin
        if (exp_iss.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          mi = exp_iss.pop_front();
          chk("m_addr", m_addr, mi.addr);
          chk("m_we", m_we, mi.we);
          chk("m_size", m_size, mi.size);
          chk("m_wdata", m_wdata, mi.wdata);
        end
        rd_cyc = cyc + LAT;
        rd_val = mem_val(m_addr);
      end else begin
        chk("m_we_idle", m_we, 0);
      end
      if (i_valid || d_valid) begin
        chk("valid_both", i_valid && d_valid, 0);
        if (exp_rsp.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          mr = exp_rsp.pop_front();
          chk("resp_owner", d_valid, mr.own_d);
          chk("resp_cycle", cyc, mr.at);
          chk("i_rdata", i_rdata, mr.ird);
          chk("d_rdata", d_rdata, mr.drd);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    i_req = 1'b1; d_req = 1'b1;
    repeat (2) begin
      @(posedge clock); #2;
      check_zero("reset");
    end
    // Lone fetch immediately after reset release.
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    apply(1'b1, 1'b0, 32'h0040_0000, '0, 1'b0, 2'b00, '0);
    idle_until_free();
    // Byte store, then a load to the same address.
    @(posedge clock); #1;
    apply(1'b0, 1'b1, '0, 32'h1001_0003, 1'b1, 2'b00, 32'h41);
    idle_until_free();
    @(posedge clock); #1;
    apply(1'b0, 1'b1, '0, 32'h1001_0003, 1'b0, 2'b00, 32'h0);
    idle_until_free();
    // Both requests held across four transactions, then data drops.
    for (int k = 0; k < 4 * (LAT + 3) + 1; k++) begin
      @(posedge clock); #1;
      apply(1'b1, 1'b1, $urandom(), $urandom(), 1'($urandom()), 2'($urandom()), $urandom());
    end
    for (int k = 0; k < 2 * (LAT + 3); k++) begin
      @(posedge clock); #1;
      apply(1'b1, 1'b0, $urandom(), $urandom(), 1'b0, 2'b00, $urandom());
    end
    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      @(posedge clock); #1;
      apply(($urandom() % 3) != 0, ($urandom() % 3) != 0, $urandom(), $urandom(),
            1'($urandom()), 2'($urandom()), $urandom());
    end
    idle_until_free();
    // Reset in the middle of a load aborts it without a response.
    @(posedge clock); #1;
    t0 = cyc;
    apply(1'b0, 1'b1, '0, 32'h2000_0040, 1'b0, 2'b10, '0);
    chk("abort_accept", last_acc, t0);
    repeat (2) begin
      @(posedge clock); #1;
      apply(1'b0, 1'b0, '0, '0, 1'b0, 2'b00, '0);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    exp_iss.delete();
    exp_rsp.delete();
    #1;
    check_zero("midreset");
    repeat (LAT + 2) begin
      @(posedge clock); #2;
      check_zero("midreset_hold");
    end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    apply(1'b1, 1'b1, 32'h0040_0010, 32'h1000_0000, 1'b0, 2'b11, '0);
    idle_until_free();
    repeat (LAT + 4) begin
      @(posedge clock); #1;
      apply(1'b0, 1'b0, '0, '0, 1'b0, 2'b00, '0);
    end
    chk("issue_left", exp_iss.size(), 0);
    chk("resp_left", exp_rsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
